// File: rtl/icache_param_if.sv
// Bundles the datapath instruction port and the memory-controller instruction channel.
// master: drives requests and memory responses (datapath + memory side).
// slave:  the cache; drives hit/load toward the datapath and read requests toward memory.
interface icache_param_if;
  logic        imemREN;   // datapath read request
  logic [31:0] imemaddr;  // datapath byte address
  logic        ihit;      // imemload valid this cycle
  logic [31:0] imemload;  // instruction word
  logic        iREN;      // memory read request
  logic [31:0] iaddr;     // memory word address
  logic [31:0] iload;     // memory read data
  logic        iwait;     // memory busy

  modport master (
    output imemREN, imemaddr, iload, iwait,
    input  ihit, imemload, iREN, iaddr
  );

  modport slave (
    input  imemREN, imemaddr, iload, iwait,
    output ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_param.sv
// Direct-mapped read-only instruction cache with same-cycle hits and a counter-driven block fill.
// Ports: CLK/RST (sync, active-high), bus (icache_param_if.slave), flush, hit_count/miss_count.
// Backpressure: memory stalls the fill via iwait; the datapath sees ihit=0 until the line is valid.
module icache_param #(
  parameter int NSETS    = 16,
  parameter int BLKWORDS = 2,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  icache_param_if.slave    bus,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int WOFF = $clog2(BLKWORDS);
  localparam int IDX  = $clog2(NSETS);
  localparam int TAGW = 30 - WOFF - IDX;
  // Word counter needs at least one bit even for single-word lines.
  localparam int CW   = (WOFF == 0) ? 1 : WOFF;
  // Clears byte and word offset bits to form the block base address.
  localparam logic [31:0] BLK_MASK = ~((32'(BLKWORDS) << 2) - 32'd1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic [IDX-1:0]  fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic [31:0]     fill_base;

  logic [NSETS-1:0] valid;
  logic [TAGW-1:0]  tags [NSETS];
  logic [31:0]      data [NSETS][BLKWORDS];

  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;
  logic [CW-1:0]   req_woff;
  logic            tag_match;
  logic            lookup_hit;
  logic            miss;
  logic            accept;
  logic            last;
  logic            unused_addr_bits;

  assign req_idx = bus.imemaddr[2+WOFF +: IDX];
  assign req_tag = bus.imemaddr[31 -: TAGW];
  assign unused_addr_bits = ^bus.imemaddr[1:0];

  generate
    if (WOFF > 0) begin : g_woff
      assign req_woff = bus.imemaddr[2 +: CW];
    end else begin : g_no_woff
      assign req_woff = '0;
    end
  endgenerate

  assign tag_match  = valid[req_idx] && (tags[req_idx] == req_tag);
  // Only IDLE serves lookups; the line under fill stays invisible until its valid bit is set.
  assign lookup_hit = (state == IDLE) && bus.imemREN && tag_match && !flush && !RST;
  assign miss       = (state == IDLE) && bus.imemREN && !tag_match && !flush;
  assign accept     = (state == FETCH) && !bus.iwait;
  assign last       = (cnt == CW'(BLKWORDS - 1));

  assign bus.ihit     = lookup_hit;
  assign bus.imemload = lookup_hit ? data[req_idx][req_woff] : 32'd0;
  assign bus.iREN     = (state == FETCH);
  assign bus.iaddr    = (state == FETCH) ? (fill_base + (32'(cnt) << 2)) : 32'd0;

  // Control state, tags and valid bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      fill_idx   <= '0;
      fill_tag   <= '0;
      fill_base  <= '0;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int i = 0; i < NSETS; i++) tags[i] <= '0;
    end else if (flush) begin
      // An in-flight fill is dropped; its line never got its valid bit.
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
    end else begin
      if (lookup_hit && (hit_count != '1)) hit_count <= hit_count + 1'b1;
      case (state)
        IDLE: begin
          if (miss) begin
            state     <= FETCH;
            cnt       <= '0;
            fill_idx  <= req_idx;
            fill_tag  <= req_tag;
            fill_base <= bus.imemaddr & BLK_MASK;
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            if (last) begin
              state           <= IDLE;
              cnt             <= '0;
              tags[fill_idx]  <= fill_tag;
              valid[fill_idx] <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Data array carries no reset; valid bits gate every read.
  always_ff @(posedge CLK) begin
    if (accept && !flush && !RST) data[fill_idx][cnt] <= bus.iload;
  end

endmodule

// File: tb/tb_icache_param.sv
module tb_icache_param;
  logic       CLK;
  logic       RST;
  logic       flush;
  logic [3:0] hit_count;
  logic [3:0] miss_count;

  icache_param_if bus ();

  icache_param #(.NSETS(16), .BLKWORDS(2), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .flush(flush),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory content: word at 0x40 is 0xAAAA0001, each following word adds one.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = ((a - 32'h40) >> 2) + 32'd1;
    return {16'hAAAA, w[15:0]};
  endfunction

  always_comb bus.iload = mem_word(bus.iaddr);

  typedef struct {
    bit          chk;
    bit          rst;
    bit          ren;
    logic [31:0] addr;
    bit          iw;
    bit          fl;
    bit          e_hit;
    logic [31:0] e_load;
    bit          e_iren;
    logic [31:0] e_iaddr;
    logic [3:0]  e_hc;
    logic [3:0]  e_mc;
  } vec_t;

  vec_t vecs[$];
  int applied;
  int miscompares;

  task automatic add(input bit chk, input bit rst, input bit ren, input logic [31:0] addr,
                     input bit iw, input bit fl, input bit eh, input logic [31:0] el,
                     input bit er, input logic [31:0] ea, input int hc, input int mc);
    vec_t v;
    v.chk = chk; v.rst = rst; v.ren = ren; v.addr = addr; v.iw = iw; v.fl = fl;
    v.e_hit = eh; v.e_load = el; v.e_iren = er; v.e_iaddr = ea;
    v.e_hc = 4'(hc); v.e_mc = 4'(mc);
    vecs.push_back(v);
  endtask

  // Shorthands: reset cycle (unchecked), idle-side cycle, fetch cycle.
  task automatic rst_cyc();
    add(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask
  task automatic idle(input bit ren, input logic [31:0] a, input bit fl, input bit eh,
                      input logic [31:0] el, input int hc, input int mc);
    add(1, 0, ren, a, 0, fl, eh, el, 0, 32'h0, hc, mc);
  endtask
  task automatic fet(input bit ren, input logic [31:0] a, input bit iw, input bit fl,
                     input logic [31:0] ea, input int hc, input int mc);
    add(1, 0, ren, a, iw, fl, 0, 32'h0, 1, ea, hc, mc);
  endtask

  initial begin
    int hc;
    int cyc;
    bit got_hit;
    bit bad_addr;
    logic [31:0] got_load;

    applied = 0;
    miscompares = 0;
    RST = 1'b1; flush = 1'b0;
    bus.imemREN = 1'b0; bus.imemaddr = 32'h0; bus.iwait = 1'b0;

    // Basic miss, fill, hit, then a conflicting tag on index 8.
    rst_cyc();
    idle(0, 32'h0,   0, 0, 32'h0, 0, 0);            // reset state
    idle(1, 32'h40,  0, 0, 32'h0, 0, 0);            // miss detect
    fet (1, 32'h40,  0, 0, 32'h40, 0, 1);
    fet (1, 32'h40,  0, 0, 32'h44, 0, 1);
    idle(1, 32'h40,  0, 1, 32'hAAAA0001, 0, 1);
    idle(1, 32'h44,  0, 1, 32'hAAAA0002, 1, 1);
    idle(0, 32'h0,   0, 0, 32'h0, 2, 1);
    idle(1, 32'h440, 0, 0, 32'h0, 2, 1);
    fet (1, 32'h440, 0, 0, 32'h440, 2, 2);
    fet (1, 32'h440, 0, 0, 32'h444, 2, 2);
    idle(1, 32'h440, 0, 1, 32'hAAAA0101, 2, 2);
    idle(1, 32'h40,  0, 0, 32'h0, 3, 2);            // replaced line misses
    fet (1, 32'h40,  0, 0, 32'h40, 3, 3);
    fet (1, 32'h40,  0, 0, 32'h44, 3, 3);
    idle(1, 32'h40,  0, 1, 32'hAAAA0001, 3, 3);

    // Memory stalls three cycles per word; request address wanders mid-fill.
    rst_cyc();
    idle(1, 32'h40, 0, 0, 32'h0, 0, 0);
    fet (1, 32'h40, 1, 0, 32'h40, 0, 1);
    fet (1, 32'h80, 1, 0, 32'h40, 0, 1);
    fet (1, 32'h80, 1, 0, 32'h40, 0, 1);
    fet (0, 32'h0,  0, 0, 32'h40, 0, 1);
    fet (1, 32'h40, 1, 0, 32'h44, 0, 1);
    fet (0, 32'hC0, 1, 0, 32'h44, 0, 1);
    fet (1, 32'h40, 1, 0, 32'h44, 0, 1);
    fet (1, 32'h40, 0, 0, 32'h44, 0, 1);
    idle(1, 32'h40, 0, 1, 32'hAAAA0001, 0, 1);

    // Flush during the second fill cycle, then flush of a filled line.
    rst_cyc();
    idle(1, 32'h40, 0, 0, 32'h0, 0, 0);
    fet (1, 32'h40, 0, 0, 32'h40, 0, 1);
    fet (1, 32'h40, 0, 1, 32'h44, 0, 1);
    idle(0, 32'h0,  0, 0, 32'h0, 0, 1);
    idle(1, 32'h40, 0, 0, 32'h0, 0, 1);
    fet (1, 32'h40, 0, 0, 32'h40, 0, 2);
    fet (1, 32'h40, 0, 0, 32'h44, 0, 2);
    idle(1, 32'h40, 0, 1, 32'hAAAA0001, 0, 2);
    idle(1, 32'h40, 1, 0, 32'h0, 1, 2);             // flush masks the hit
    idle(1, 32'h40, 0, 0, 32'h0, 1, 2);
    fet (1, 32'h40, 0, 0, 32'h40, 1, 3);
    fet (1, 32'h40, 0, 0, 32'h44, 1, 3);
    idle(1, 32'h40, 0, 1, 32'hAAAA0001, 1, 3);

    // Hit counter saturation at 4 bits.
    hc = 2;
    for (int i = 0; i < 20; i++) begin
      idle(1, 32'h44, 0, 1, 32'hAAAA0002, hc, 3);
      if (hc < 15) hc++;
    end
    idle(0, 32'h0, 0, 0, 32'h0, 15, 3);

    // Reset in the middle of a fill.
    idle(1, 32'h80, 0, 0, 32'h0, 15, 3);
    fet (1, 32'h80, 0, 0, 32'h80, 15, 4);
    rst_cyc();
    idle(1, 32'h44, 0, 0, 32'h0, 0, 0);
    fet (1, 32'h44, 0, 0, 32'h40, 0, 1);
    fet (1, 32'h44, 0, 0, 32'h44, 0, 1);
    idle(1, 32'h44, 0, 1, 32'hAAAA0002, 0, 1);

    // Flush coinciding with the last-word accept leaves the line invalid.
    idle(1, 32'h80, 0, 0, 32'h0, 1, 1);
    fet (1, 32'h80, 0, 0, 32'h80, 1, 2);
    fet (1, 32'h80, 0, 1, 32'h84, 1, 2);
    idle(1, 32'h80, 0, 0, 32'h0, 1, 2);
    fet (1, 32'h80, 0, 0, 32'h80, 1, 3);
    fet (1, 32'h80, 0, 0, 32'h84, 1, 3);
    idle(1, 32'h80, 0, 1, 32'hAAAA0011, 1, 3);

    foreach (vecs[k]) begin
      RST = vecs[k].rst; flush = vecs[k].fl;
      bus.imemREN = vecs[k].ren; bus.imemaddr = vecs[k].addr; bus.iwait = vecs[k].iw;
      @(negedge CLK);
      if (vecs[k].chk) begin
        applied++;
        if (bus.ihit !== vecs[k].e_hit || bus.imemload !== vecs[k].e_load ||
            bus.iREN !== vecs[k].e_iren || bus.iaddr !== vecs[k].e_iaddr ||
            hit_count !== vecs[k].e_hc || miss_count !== vecs[k].e_mc) begin
          miscompares++;
          $display("FAIL vec%0d: got ihit=%0b load=%h iREN=%0b iaddr=%h hc=%0d mc=%0d, need ihit=%0b load=%h iREN=%0b iaddr=%h hc=%0d mc=%0d",
                   k, bus.ihit, bus.imemload, bus.iREN, bus.iaddr, hit_count, miss_count,
                   vecs[k].e_hit, vecs[k].e_load, vecs[k].e_iren, vecs[k].e_iaddr,
                   vecs[k].e_hc, vecs[k].e_mc);
        end
      end
      @(posedge CLK); #1;
    end

    // Conflict fill on index 0 under random memory stalls, bounded wait for the hit.
    RST = 1'b0; flush = 1'b0;
    bus.imemREN = 1'b1; bus.imemaddr = 32'h100;
    got_hit = 1'b0; bad_addr = 1'b0; got_load = 32'h0;
    for (cyc = 0; cyc < 64 && !got_hit; cyc++) begin
      bus.iwait = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (bus.iREN && bus.iaddr != 32'h100 && bus.iaddr != 32'h104) bad_addr = 1'b1;
      if (bus.ihit) begin
        got_hit = 1'b1;
        got_load = bus.imemload;
      end
      @(posedge CLK); #1;
    end
    applied++;
    if (!got_hit || bad_addr || got_load !== 32'hAAAA0031) begin
      miscompares++;
      $display("FAIL stall_fill: got hit=%0b load=%h bad_iaddr=%0b, need hit=1 load=aaaa0031 bad_iaddr=0",
               got_hit, got_load, bad_addr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/icache_param.md
Name: icache_param

Overview:
- Parametrised direct-mapped instruction cache, sitting between the datapath instruction port and the memory-controller instruction channel.
- Replaces the single-cycle instruction pass-through in the caches block.
- Hits return in the same cycle. Misses fetch a multi-word block through a counter-driven fill FSM.
- Adds flush and hit/miss performance counters.

Parameters:
NSETS, 16, number of lines; power of two, 2..256
BLKWORDS, 2, 32-bit words per line; power of two, 1..8
CNT_W, 32, width of each performance counter

Ports:
CLK  in  1  clock; everything samples on posedge
RST  in  1  synchronous active-high reset
imemREN  in  1  datapath instruction read request
imemaddr  in  32  datapath byte address; bits [1:0] ignored
ihit  out  1  requested word valid on imemload this cycle
imemload  out  32  instruction word
iREN  out  1  memory read request
iaddr  out  32  memory word address, word-aligned
iload  in  32  memory read data
iwait  in  1  memory busy; data valid when iREN=1 and iwait=0
flush  in  1  invalidate all lines
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Interface (already decided): one clock CLK; reset RST is synchronous and active-high.
- Address split:
  - byte offset [1:0]
  - word offset next WOFF=log2(BLKWORDS) bits (0 when BLKWORDS=1)
  - index next IDX=log2(NSETS) bits
  - tag = remaining upper bits
- Storage: per line a valid bit, a tag, and BLKWORDS data words. Only valid bits and tags need a reset; data is don't-care.
- Reset (RST=1 at posedge):
  - all valid bits cleared
  - state=IDLE, word counter=0, both counters=0
  - ihit=0, iREN=0, iaddr=0, imemload=0 (imemload forced 0 when ihit=0)
- States:
  - IDLE:
    - Hit is combinational: imemREN & valid[idx] & tag match.
    - On a hit: ihit=1, imemload=data[idx][woff], same-cycle latency.
    - On a miss (imemREN & !hit & !flush): latch block base address (word offset zeroed) and index/tag, clear word counter, go to FETCH.
  - FETCH:
    - iREN=1, iaddr = base + 4*counter.
    - When iwait=0: write iload into data[idx][counter], increment counter.
    - On the last word (counter==BLKWORDS-1, iwait=0): write tag, set valid, go to IDLE.
    - ihit=0 throughout FETCH.
- Miss latency with iwait held 0: detect in cycle 0, fill cycles 1..BLKWORDS, hit in cycle BLKWORDS+1.
- FETCH is insensitive to imemaddr changes and to imemREN dropping. The fill always completes for the latched address.
- Flush:
  - In any state, flush=1 at posedge clears all valid bits, state→IDLE, counter→0.
  - A fill in progress is aborted; its line is left invalid.
  - ihit is forced 0 in any cycle flush=1.
- The line under fill is not readable until valid is set; no critical-word-first.
- Counters:
  - hit_count +1 in each cycle ihit=1.
  - miss_count +1 on each IDLE→FETCH transition.
  - Both saturate at all-ones.
  - Neither changes during reset or on a flush cycle.
- Conflict: a miss to a valid line with a different tag overwrites that line; no writeback (read-only cache).

Test Plan:
(defaults NSETS=16, BLKWORDS=2; index=[6:3], woff=[2], tag=[31:7])
- Reset then imemREN=1, imemaddr=0x0000_0040, memory returns 0xAAAA0001 @0x40 and 0xAAAA0002 @0x44 with iwait=0 → iREN high 2 cycles, iaddr 0x40 then 0x44; ihit=1, imemload=0xAAAA0001 on cycle 3; miss_count=1, hit_count=1.
- Then request 0x44 → ihit same cycle, imemload=0xAAAA0002, no iREN; hit_count=2.
- Request 0x0000_0440 (same index 8, different tag) → miss and refill, line replaced; re-request 0x40 → miss again; miss_count=3.
- iwait=1 for 3 cycles on each word → iaddr holds 0x40 for 4 cycles and then 0x44 for 4 cycles; ihit only after the second word is accepted; imemaddr changed mid-fill does not alter iaddr.
- flush asserted during the second FETCH cycle → next cycle IDLE, iREN=0; re-request 0x40 misses; also a flush after lines are filled → all subsequent requests miss.
- CNT_W=4: 20 consecutive hits → hit_count saturates at 15; RST mid-FETCH → iREN=0 next cycle, counters 0, all lines invalid.
